axi_burst_master: RTL and testbench
===================================

Name: axi_burst_master

Overview:
- Single-outstanding AXI3-style burst initiator. It is the bus-master counterpart to the bench's AXI slave models.
- Accepts one command at a time: a read or write burst with start address and beat count.
- Drives the AW/W/B or AR/R channels and streams data to/from simple valid/ready ports.
- Used by the DMAC and by benches as a reusable bus driver.

Parameters:
- ADDR_WIDTH, 32, address width of cmd_addr/awaddr/araddr
- DATA_WIDTH, 32, data bus width; beat size = DATA_WIDTH/8 bytes
- ID_WIDTH, 4, width of awid/arid; driven constant 0

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- cmd_valid/cmd_ready  in/out  1/1  command handshake
- cmd_write  input  1  1=write burst, 0=read burst
- cmd_addr  input  ADDR_WIDTH  start address, beat-aligned
- cmd_len  input  4  beats minus one (1..16 beats)
- wd_valid/wd_ready  in/out  1/1  write-data stream handshake
- wd_data  input  DATA_WIDTH  write beat
- rd_valid/rd_ready  out/in  1/1  read-data stream handshake
- rd_data  output  DATA_WIDTH  read beat
- done  output  1  one-cycle pulse at burst completion
- err  output  1  valid with done; 1 if any SLVERR/DECERR
- awid,awaddr,awlen,awsize,awburst,awvalid / awready  out / in  ID,ADDR,4,3,2,1 / 1
- wid,wdata,wstrb,wlast,wvalid / wready  out / in  ID,DATA,DATA/8,1,1 / 1
- bid,bresp,bvalid / bready  in / out  ID,2,1 / 1
- arid,araddr,arlen,arsize,arburst,arvalid / arready  out / in  ID,ADDR,4,3,2,1 / 1
- rid,rdata,rresp,rlast,rvalid / rready  in / out  ID,DATA,2,1,1 / 1

Behaviour:
- Reset values: all *valid, bready, rready, done, err, cmd_ready=0 in the reset cycle; addresses/data/len=0. cmd_ready=1 from the first IDLE cycle after reset.
- Reset mid-burst aborts immediately to IDLE with no completion pulse. The environment must also reset the slave.
- FSM states: IDLE, WADDR, WDATA, WRESP, RADDR, RDATA.
- IDLE: cmd_ready=1. On cmd_valid, latch addr/len/write, clear beat counter and err, then go to WADDR or RADDR.
- WADDR: awvalid=1 with awlen=len, awsize=log2(DATA_WIDTH/8), awburst=INCR(01). On awready go to WDATA. awvalid must hold, and AW fields must stay stable, until accepted.
- WDATA: wvalid=wd_valid, wd_ready=wready (combinational pass-through, zero latency). wstrb is all ones. wlast=1 when beat counter==len. A beat transfers when wvalid&wready; the counter increments. Last beat goes to WRESP.
- WRESP: bready=1. On bvalid, err=bresp[1], done pulses, return to IDLE.
- RADDR: same rules as WADDR on the AR channel, then go to RDATA.
- RDATA: rd_valid=rvalid, rready=rd_ready, rd_data=rdata. err |= rresp[1] per beat. On a beat with rlast, done pulses next cycle and the FSM returns to IDLE.
- Beat count check: rlast asserted on a beat count ≠ len sets err. The burst still ends on rlast.
- Back-to-back: a new command is accepted in the first IDLE cycle after done. Minimum one idle cycle between bursts.
- Slave tied-high readies/valids (awready=wready=bvalid=1) must complete a write in len+4 cycles from cmd accept.
- bvalid arriving before WRESP is ignored until WRESP.

Optional Feature:
- Macro: AXI_MASTER_4K_CHECK_EN.
- Defined: in IDLE, a command where (addr[11:0] + (len+1)*beat bytes) > 4096 is accepted, no bus traffic is issued, and done+err pulse on the next cycle.
- Undefined: no check; bursts are issued as commanded.

Decomposition:
- Package axi_master_pkg: state enum, AXI_BURST_INCR=2'b01, AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR, function size_of(DATA_WIDTH).
- No sub-module. Single FSM plus beat counter; the 4K check is an inline comparator.

Test Plan:
- Write, len=3, addr=0x1000, slave always-ready, bresp=OKAY -> AW awlen=3/awburst=01 once, 4 W beats with wlast on 4th only, done at cycle 7 after accept, err=0.
- Read, len=0, addr=0x2000, rdata=0xDEADBEEF, rresp=OKAY, rlast=1 -> rd_data=0xDEADBEEF, one beat, done 1 cycle later, err=0.
- Write with random wready/wd_valid stalls, len=15 -> exactly 16 beats in order, awvalid held until awready, wlast only on beat 16.
- Read with rresp=SLVERR on beat 2 of 4 -> all 4 beats delivered, done with err=1.
- Reset asserted in WDATA after 2 of 8 beats -> next cycle all valids=0; a subsequent write len=1 completes normally.
- With AXI_MASTER_4K_CHECK_EN: addr=0x0FF8, len=3, DATA_WIDTH=32 -> no awvalid, done+err next cycle. Without the macro -> burst issued.

Source files
------------

// File: rtl/axi_master_pkg.sv
// ---------------------------------------------------------------------------
// axi_master_pkg
//
// Shared types and constants for the AXI3-style burst master:
//   - state_e      : master FSM states
//   - AXI_BURST_*  : AxBURST encodings (only INCR is issued)
//   - AXI_RESP_*   : xRESP encodings (bit 1 set means an error response)
//   - size_of()    : AxSIZE encoding for a given data bus width in bits
// ---------------------------------------------------------------------------
package axi_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WADDR,
    WDATA,
    WRESP,
    RADDR,
    RDATA
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // AxSIZE is log2 of the beat size in bytes.
  function automatic logic [2:0] size_of(input int data_width);
    logic [2:0] size;
    case (data_width)
      8:       size = 3'd0;
      16:      size = 3'd1;
      32:      size = 3'd2;
      64:      size = 3'd3;
      128:     size = 3'd4;
      256:     size = 3'd5;
      512:     size = 3'd6;
      1024:    size = 3'd7;
      default: size = 3'd0;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/axi_burst_master.sv
// ---------------------------------------------------------------------------
// axi_burst_master
//
// Single-outstanding AXI3-style burst initiator. One command (read or write,
// start address, beats-1) is accepted at a time; the burst is driven on the
// AW/W/B or AR/R channels and data is streamed through simple valid/ready
// ports with zero-latency pass-through.
//
// Ports:
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   cmd_valid/ready, cmd_*    command handshake: write flag, address, len
//   wd_valid/ready, wd_data   write-data stream into the master
//   rd_valid/ready, rd_data   read-data stream out of the master
//   done, err                 one-cycle completion pulse and its error flag
//   aw*, w*, b*, ar*, r*      AXI3 master channels (IDs driven as 0)
//
// Optional feature, macro AXI_MASTER_4K_CHECK_EN:
//   when defined, a command whose burst would cross a 4 KB boundary is
//   accepted but never issued; done and err pulse on the next cycle.
// ---------------------------------------------------------------------------
module axi_burst_master
  import axi_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [3:0]              cmd_len,
  input  logic                    wd_valid,
  output logic                    wd_ready,
  input  logic [DATA_WIDTH-1:0]   wd_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    done,
  output logic                    err,
  output logic [ID_WIDTH-1:0]     awid,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [3:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [ID_WIDTH-1:0]     wid,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [ID_WIDTH-1:0]     bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic [ID_WIDTH-1:0]     arid,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [3:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [ID_WIDTH-1:0]     rid,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready
);

  state_e                  state_q, state_d;
  logic [3:0]              beat_q, beat_d;
  logic [3:0]              len_q, len_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    err_q, err_d;
  logic                    done_q, done_d;

  // IDs and the low bit of responses carry no information for this master.
  logic unused_inputs;
  assign unused_inputs = ^{bid, rid, bresp[0], rresp[0]};

  // Address-channel fields come straight from the latched command, so they
  // stay stable for as long as the address valid is held.
  assign awid    = '0;
  assign arid    = '0;
  assign wid     = '0;
  assign awaddr  = addr_q;
  assign araddr  = addr_q;
  assign awlen   = len_q;
  assign arlen   = len_q;
  assign awsize  = size_of(DATA_WIDTH);
  assign arsize  = size_of(DATA_WIDTH);
  assign awburst = AXI_BURST_INCR;
  assign arburst = AXI_BURST_INCR;
  assign wstrb   = '1;
  assign done    = done_q;
  assign err     = err_q;

`ifdef AXI_MASTER_4K_CHECK_EN
  // End offset of the burst within its 4 KB page; anything past 4096 crosses.
  localparam logic [31:0] BEAT_BYTES = 32'(DATA_WIDTH / 8);
  logic [31:0] span_end;
  logic        crosses_4k;
  assign span_end   = {20'd0, cmd_addr[11:0]} + ({28'd0, cmd_len} + 32'd1) * BEAT_BYTES;
  assign crosses_4k = span_end > 32'd4096;
`endif

  // Next-state and channel outputs. Data paths are pure pass-through in the
  // data states; everything is forced idle while reset is asserted so no
  // handshake can complete in the reset cycle.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    len_d     = len_q;
    addr_d    = addr_q;
    err_d     = err_q;
    done_d    = 1'b0;
    cmd_ready = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    wlast     = 1'b0;
    wdata     = '0;
    wd_ready  = 1'b0;
    bready    = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    rd_valid  = 1'b0;
    rd_data   = '0;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          beat_d  = 4'd0;
          err_d   = 1'b0;
          state_d = cmd_write ? WADDR : RADDR;
`ifdef AXI_MASTER_4K_CHECK_EN
          if (crosses_4k) begin
            state_d = IDLE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
`endif
        end
      end
      WADDR: begin
        awvalid = 1'b1;
        if (awready) state_d = WDATA;
      end
      WDATA: begin
        wvalid   = wd_valid;
        wd_ready = wready;
        wdata    = wd_data;
        wlast    = (beat_q == len_q);
        if (wd_valid && wready) begin
          beat_d = beat_q + 4'd1;
          if (beat_q == len_q) state_d = WRESP;
        end
      end
      WRESP: begin
        bready = 1'b1;
        if (bvalid) begin
          err_d   = bresp[1];
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      RADDR: begin
        arvalid = 1'b1;
        if (arready) state_d = RDATA;
      end
      RDATA: begin
        rd_valid = rvalid;
        rready   = rd_ready;
        rd_data  = rdata;
        if (rvalid && rd_ready) begin
          beat_d = beat_q + 4'd1;
          // A slave that ends the burst early or late is flagged as an error.
          err_d  = err_q | rresp[1] | (rlast && (beat_q != len_q));
          if (rlast) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (rst) begin
      cmd_ready = 1'b0;
      awvalid   = 1'b0;
      wvalid    = 1'b0;
      wlast     = 1'b0;
      wdata     = '0;
      wd_ready  = 1'b0;
      bready    = 1'b0;
      arvalid   = 1'b0;
      rready    = 1'b0;
      rd_valid  = 1'b0;
      rd_data   = '0;
    end
  end

  // State register; reset abandons any burst without a completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= 4'd0;
      len_q   <= 4'd0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// ---------------------------------------------------------------------------
// tb_axi_burst_master
//
// Self-checking bench for axi_burst_master. A behavioural AXI slave and
// data source/sink live inside the tasks below; each burst is described by
// what should appear on the bus (one address handshake with the commanded
// fields, len+1 data beats in order, last flag on the final beat only, a
// done pulse the cycle after the response/last beat, err from the responses).
// Honours AXI_MASTER_4K_CHECK_EN for the 4 KB crossing case.
// ---------------------------------------------------------------------------
module tb_axi_burst_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam logic [2:0] EXP_SIZE = 3'($clog2(DW / 8));

  logic            clk;
  logic            rst;
  logic            cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0]   cmd_addr;
  logic [3:0]      cmd_len;
  logic            wd_valid, wd_ready;
  logic [DW-1:0]   wd_data;
  logic            rd_valid, rd_ready;
  logic [DW-1:0]   rd_data;
  logic            done, err;
  logic [IW-1:0]   awid, wid, bid, arid, rid;
  logic [AW-1:0]   awaddr, araddr;
  logic [3:0]      awlen, arlen;
  logic [2:0]      awsize, arsize;
  logic [1:0]      awburst, arburst, bresp, rresp;
  logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic            arvalid, arready, rlast, rvalid, rready;
  logic [DW-1:0]   wdata, rdata;
  logic [DW/8-1:0] wstrb;

  int checks   = 0;
  int failures = 0;

  axi_burst_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done), .err(err),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Park every slave-side and stream input.
  task automatic idleInputs();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = '0;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = '0; rid = '0;
    wd_valid = 1'b0; wd_data = '0; rd_ready = 1'b0;
  endtask

  // Present one command for a single cycle; the master must be idle and ready.
  task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr, input logic [3:0] len);
    @(negedge clk);
    idleInputs();
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
    #1;
    checkOutput("cmd_ready", cmd_ready, 1'b1);
    @(posedge clk);
  endtask

  // Write burst against a behavioural slave. stall randomises all handshakes;
  // abort_after >= 0 asserts reset once that many beats have moved.
  task automatic doWrite(input logic [AW-1:0] addr, input logic [3:0] len, input bit stall,
                         input logic [1:0] resp, input int abort_after);
    logic [DW-1:0] data [16];
    int  beat;
    bit  aw_ok, aw_pending, b_ok, exp_done, done_next;
    for (int i = 0; i < 16; i++) data[i] = $urandom;
    beat = 0; aw_ok = 0; aw_pending = 0; b_ok = 0; exp_done = 0; done_next = 0;
    applyStimulus(1'b1, addr, len);
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      awready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      wready   = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      wd_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      wd_data  = (beat < 16) ? data[beat] : '0;
      bvalid   = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bresp    = resp;
      if (abort_after >= 0 && beat == abort_after) begin
        rst = 1'b1;
        #1;
        checkOutput("rst_cyc_wvalid", wvalid, 1'b0);
        checkOutput("rst_cyc_awvalid", awvalid, 1'b0);
        checkOutput("rst_cyc_cmd_ready", cmd_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_awvalid", awvalid, 1'b0);
        checkOutput("post_rst_wvalid", wvalid, 1'b0);
        checkOutput("post_rst_bready", bready, 1'b0);
        checkOutput("post_rst_arvalid", arvalid, 1'b0);
        checkOutput("post_rst_done", done, 1'b0);
        checkOutput("post_rst_cmd_ready", cmd_ready, 1'b1);
        return;
      end
      #1;
      checkOutput("wr_done", done, exp_done);
      if (exp_done) begin
        checkOutput("wr_err", err, resp[1]);
        checkOutput("wr_beats", beat, len + 1);
        if (!stall) checkOutput("wr_latency", cyc, len + 4);
        return;
      end
      // Response phase: only once every beat has been accepted.
      if (aw_ok && beat > len && !b_ok) begin
        checkOutput("bready", bready, 1'b1);
        if (bvalid) begin b_ok = 1; done_next = 1; end
      end else begin
        checkOutput("bready_off", bready, 1'b0);
      end
      // Data phase: pass-through after the address is accepted.
      if (aw_ok && beat <= len) begin
        checkOutput("wvalid", wvalid, wd_valid);
        checkOutput("wd_ready", wd_ready, wready);
        if (wvalid && wready) begin
          checkOutput("wdata", wdata, data[beat]);
          checkOutput("wlast", wlast, beat == len);
          checkOutput("wstrb", wstrb, 4'hF);
          beat++;
        end
      end else begin
        checkOutput("wvalid_off", wvalid, 1'b0);
      end
      // Address phase: exactly one handshake, held until accepted.
      if (!aw_ok) begin
        if (aw_pending) checkOutput("aw_hold", awvalid, 1'b1);
        if (awvalid) begin
          checkOutput("awaddr", awaddr, addr);
          checkOutput("awlen", awlen, len);
          checkOutput("awsize", awsize, EXP_SIZE);
          checkOutput("awburst", awburst, 2'b01);
          checkOutput("awid", awid, 0);
        end
        aw_pending = awvalid && !awready;
        if (awvalid && awready) aw_ok = 1;
      end else begin
        checkOutput("aw_again", awvalid, 1'b0);
      end
      exp_done = done_next;
      done_next = 0;
    end
    checkOutput("wr_timeout", done, 1'b1);
  endtask

  // Read burst. err_beat (-1 for none) gets SLVERR; rlast is placed on beat
  // last_at, which may differ from len to exercise the beat-count check.
  task automatic doRead(input logic [AW-1:0] addr, input logic [3:0] len, input bit stall,
                        input int err_beat, input int last_at);
    logic [DW-1:0] data [17];
    int  beat;
    bit  ar_ok, ar_pending, exp_done, done_next, exp_err;
    for (int i = 0; i < 17; i++) data[i] = $urandom;
    if (addr == 32'h2000) data[0] = 32'hDEADBEEF;
    exp_err = (err_beat >= 0 && err_beat <= last_at) || (last_at != int'(len));
    beat = 0; ar_ok = 0; ar_pending = 0; exp_done = 0; done_next = 0;
    applyStimulus(1'b0, addr, len);
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      arready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      rd_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ar_ok && beat <= last_at) begin
        rvalid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        rdata  = data[beat];
        rresp  = (beat == err_beat) ? 2'b10 : 2'b00;
        rlast  = (beat == last_at);
      end else begin
        rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
      end
      #1;
      checkOutput("rd_done", done, exp_done);
      if (exp_done) begin
        checkOutput("rd_err", err, exp_err);
        checkOutput("rd_beats", beat, last_at + 1);
        if (!stall) checkOutput("rd_latency", cyc, last_at + 3);
        return;
      end
      if (ar_ok) begin
        checkOutput("ar_again", arvalid, 1'b0);
        checkOutput("rd_valid", rd_valid, rvalid);
        checkOutput("rready", rready, rd_ready);
        if (rvalid && rready) begin
          checkOutput("rd_data", rd_data, data[beat]);
          if (rlast) done_next = 1;
          beat++;
        end
      end else begin
        checkOutput("rready_off", rready, 1'b0);
        if (ar_pending) checkOutput("ar_hold", arvalid, 1'b1);
        if (arvalid) begin
          checkOutput("araddr", araddr, addr);
          checkOutput("arlen", arlen, len);
          checkOutput("arsize", arsize, EXP_SIZE);
          checkOutput("arburst", arburst, 2'b01);
        end
        ar_pending = arvalid && !arready;
        if (arvalid && arready) ar_ok = 1;
      end
      exp_done = done_next;
      done_next = 0;
    end
    checkOutput("rd_timeout", done, 1'b1);
  endtask

  initial begin
    logic [31:0] tmp;
    logic [AW-1:0] raddr;
    logic [3:0]    rlen;
    int            eb;

    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    idleInputs();

    // Reset cycle: everything quiet, fields cleared.
    @(negedge clk);
    #1;
    checkOutput("rst_cmd_ready", cmd_ready, 1'b0);
    checkOutput("rst_awvalid", awvalid, 1'b0);
    checkOutput("rst_arvalid", arvalid, 1'b0);
    checkOutput("rst_bready", bready, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_err", err, 1'b0);
    checkOutput("rst_awaddr", awaddr, 0);
    checkOutput("rst_awlen", awlen, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("idle_cmd_ready", cmd_ready, 1'b1);

    $display("[TB] directed bursts");
    doWrite(32'h1000, 4'd3, 1'b0, 2'b00, -1);
    doRead(32'h2000, 4'd0, 1'b0, -1, 0);
    doWrite(32'h1800, 4'd15, 1'b1, 2'b00, -1);
    doRead(32'h3000, 4'd3, 1'b1, 1, 3);
    doWrite(32'h4000, 4'd7, 1'b0, 2'b00, 2);
    doWrite(32'h5000, 4'd1, 1'b0, 2'b00, -1);
    doWrite(32'h5100, 4'd2, 1'b0, 2'b10, -1);
    doWrite(32'h5200, 4'd0, 1'b1, 2'b11, -1);
    doRead(32'h6000, 4'd3, 1'b0, -1, 2);
    doRead(32'h6100, 4'd3, 1'b1, -1, 5);
    doRead(32'h6200, 4'd15, 1'b0, -1, 15);

    $display("[TB] 4K boundary case");
`ifdef AXI_MASTER_4K_CHECK_EN
    applyStimulus(1'b1, 32'h0FF8, 4'd3);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    checkOutput("4k_done", done, 1'b1);
    checkOutput("4k_err", err, 1'b1);
    checkOutput("4k_awvalid", awvalid, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("4k_done_clear", done, 1'b0);
    checkOutput("4k_awvalid_after", awvalid, 1'b0);
    checkOutput("4k_cmd_ready", cmd_ready, 1'b1);
`else
    doWrite(32'h0FF8, 4'd3, 1'b0, 2'b00, -1);
`endif

    $display("[TB] randomized bursts");
    for (int n = 0; n < 16; n++) begin
      tmp   = $urandom;
      raddr = {tmp[31:12], 4'($urandom_range(0, 15)), 8'h00};
      rlen  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        doWrite(raddr, rlen, 1'b1, 2'($urandom_range(0, 3)), -1);
      end else begin
        eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, rlen)) : -1;
        doRead(raddr, rlen, 1'b1, eb, int'(rlen));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
